// File: rtl/t01_rv_pkg.sv
// Shared RISC-V decode constants: immediate format tags, opcodes and pipe states.
package t01_rv_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned FMT_W   = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic [OPC_W-1:0] OP_LOAD   = 7'h03;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'h13;
    localparam logic [OPC_W-1:0] OP_IMM32  = 7'h1b;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'h67;
    localparam logic [OPC_W-1:0] OP_SYSTEM = 7'h73;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'h23;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'h63;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'h37;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'h17;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'h6f;
    localparam logic [OPC_W-1:0] OP_OP     = 7'h33;
    localparam logic [OPC_W-1:0] OP_OP32   = 7'h3b;
    localparam logic [OPC_W-1:0] OP_FENCE  = 7'h0f;

endpackage

// File: rtl/t01_imm_decode.sv
// Combinational immediate extraction: format tag, sign-extended immediate, illegal-opcode flag.
module t01_imm_decode
    import t01_rv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_W-1:0] i_instr,
    output logic [XLEN-1:0]    o_imm_c,
    output fmt_e               o_fmt_c,
    output logic               o_illegal_c
);

    logic [INSTR_W-1:0] w_imm32;

    // Every format fits in 32 bits with bit 31 as sign; widening to XLEN happens once below.
    always_comb begin
        w_imm32     = '0;
        o_fmt_c     = FMT_NONE;
        o_illegal_c = 1'b0;
        case (i_instr[6:0])
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM: begin
                o_fmt_c = FMT_I;
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            OP_STORE: begin
                o_fmt_c = FMT_S;
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            OP_BRANCH: begin
                o_fmt_c = FMT_B;
                w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                o_fmt_c = FMT_U;
                w_imm32 = {i_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                o_fmt_c = FMT_J;
                w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
            end
            OP_OP, OP_OP32, OP_FENCE: begin
                o_fmt_c = FMT_NONE;
            end
            default: begin
                o_illegal_c = 1'b1;
            end
        endcase
    end

    assign o_imm_c = XLEN'($signed(w_imm32));

endmodule

// File: rtl/t01_imm_gen_pipe.sv
// Immediate generator behind a one-cycle valid/ready stage, optionally with a skid entry.
module t01_imm_gen_pipe
    import t01_rv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter bit          SKID = 1'b1
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_imm,
    output logic [FMT_W-1:0]   out_fmt,
    output logic [XLEN-1:0]    out_target,
    output logic [XLEN-1:0]    out_pc,
    output logic               out_illegal
);

    logic [XLEN-1:0] w_imm;
    fmt_e            w_fmt;
    logic            w_illegal;
    logic [XLEN-1:0] w_target;

    state_e r_state;
    state_e w_state_nxt;
    logic   r_out_valid;
    logic   w_accept;
    logic   w_drain;
    logic   w_load_out_in;
    logic   w_load_out_skid;
    logic   w_load_skid;

    logic [XLEN-1:0] r_out_imm, r_out_pc, r_out_tgt;
    fmt_e            r_out_fmt;
    logic            r_out_ill;
    logic [XLEN-1:0] r_skid_imm, r_skid_pc, r_skid_tgt;
    fmt_e            r_skid_fmt;
    logic            r_skid_ill;

    t01_imm_decode #(.XLEN(XLEN)) u_dec (
        .i_instr     (in_instr),
        .o_imm_c     (w_imm),
        .o_fmt_c     (w_fmt),
        .o_illegal_c (w_illegal)
    );

    assign w_target = in_pc + w_imm;
    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_out_valid & out_ready;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Flush wins over any simultaneous accept or drain.
    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt   = ST_ONE;
                        w_load_out_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_drain) begin
                        if (SKID) begin
                            w_state_nxt = ST_TWO;
                            w_load_skid = 1'b1;
                        end
                    end else if (w_accept) begin
                        w_load_out_in = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_drain) begin
                        w_state_nxt     = ST_ONE;
                        w_load_out_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_out_imm <= '0;
            r_out_pc  <= '0;
            r_out_tgt <= '0;
            r_out_fmt <= FMT_NONE;
            r_out_ill <= 1'b0;
        end else if (w_load_out_in) begin
            r_out_imm <= w_imm;
            r_out_pc  <= in_pc;
            r_out_tgt <= w_target;
            r_out_fmt <= w_fmt;
            r_out_ill <= w_illegal;
        end else if (w_load_out_skid) begin
            r_out_imm <= r_skid_imm;
            r_out_pc  <= r_skid_pc;
            r_out_tgt <= r_skid_tgt;
            r_out_fmt <= r_skid_fmt;
            r_out_ill <= r_skid_ill;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_skid_imm <= '0;
            r_skid_pc  <= '0;
            r_skid_tgt <= '0;
            r_skid_fmt <= FMT_NONE;
            r_skid_ill <= 1'b0;
        end else if (w_load_skid) begin
            r_skid_imm <= w_imm;
            r_skid_pc  <= in_pc;
            r_skid_tgt <= w_target;
            r_skid_fmt <= w_fmt;
            r_skid_ill <= w_illegal;
        end
    end

    // Skid variant registers in_ready to break the out_ready -> in_ready path.
    generate
        if (SKID) begin : g_rdy_reg
            logic r_in_ready;
            always_ff @(posedge clk or negedge nRst) begin
                if (!nRst) begin
                    r_in_ready <= 1'b0;
                end else begin
                    r_in_ready <= (w_state_nxt != ST_TWO);
                end
            end
            assign in_ready = r_in_ready;
        end else begin : g_rdy_comb
            logic r_rst_done;
            always_ff @(posedge clk or negedge nRst) begin
                if (!nRst) begin
                    r_rst_done <= 1'b0;
                end else begin
                    r_rst_done <= 1'b1;
                end
            end
            assign in_ready = r_rst_done & (!r_out_valid | out_ready);
        end
    endgenerate

    assign out_valid   = r_out_valid;
    assign out_imm     = r_out_imm;
    assign out_pc      = r_out_pc;
    assign out_target  = r_out_tgt;
    assign out_fmt     = r_out_fmt;
    assign out_illegal = r_out_ill;

endmodule

// File: tb/tb_t01_imm_gen_pipe.sv
// Bench for t01_imm_gen_pipe: 32/64-bit skid variants and the single-register variant against a queue model.
module tb_t01_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        nRst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_imm, a_out_target, a_out_pc;
    logic [2:0]  a_out_fmt;
    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [63:0] b_out_imm, b_out_target, b_out_pc;
    logic [2:0]  b_out_fmt;
    logic        c_in_ready, c_out_valid, c_out_illegal;
    logic [31:0] c_out_imm, c_out_target, c_out_pc;
    logic [2:0]  c_out_fmt;

    always #5 clk = ~clk;

    t01_imm_gen_pipe #(.XLEN(32), .SKID(1'b1)) u_a (
        .clk(clk), .nRst(nRst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_target(a_out_target), .out_pc(a_out_pc),
        .out_illegal(a_out_illegal));

    t01_imm_gen_pipe #(.XLEN(64), .SKID(1'b1)) u_b (
        .clk(clk), .nRst(nRst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_target(b_out_target), .out_pc(b_out_pc),
        .out_illegal(b_out_illegal));

    t01_imm_gen_pipe #(.XLEN(32), .SKID(1'b0)) u_c (
        .clk(clk), .nRst(nRst), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_imm(c_out_imm), .out_fmt(c_out_fmt), .out_target(c_out_target), .out_pc(c_out_pc),
        .out_illegal(c_out_illegal));

    typedef struct {
        logic [63:0] imm;
        logic [63:0] pc;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } ent_t;

    ent_t qa[$];
    ent_t qc[$];
    bit   rdy_a, rdy_c_en, acc_a_last;
    int   n_tests, n_fail;

    function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
        logic [63:0] m;
        m = ~64'd0 << bits;
        return v[bits-1] ? (v | m) : (v & ~m);
    endfunction

    // Reference decode built from bit-weighted field sums, then 64-bit sign extension.
    function automatic ent_t model(input logic [31:0] ins, input logic [63:0] pc);
        ent_t e;
        e.imm = 64'd0; e.fmt = 3'd0; e.ill = 1'b0; e.pc = pc;
        case (ins[6:0])
            7'h03, 7'h13, 7'h1b, 7'h67, 7'h73: begin
                e.fmt = 3'd1; e.imm = sext(64'(ins[31:20]), 12);
            end
            7'h23: begin
                e.fmt = 3'd2; e.imm = sext((64'(ins[31:25]) << 5) | 64'(ins[11:7]), 12);
            end
            7'h63: begin
                e.fmt = 3'd3;
                e.imm = sext((64'(ins[31]) << 12) | (64'(ins[7]) << 11) |
                             (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1), 13);
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4; e.imm = sext(64'(ins[31:12]) << 12, 32);
            end
            7'h6f: begin
                e.fmt = 3'd5;
                e.imm = sext((64'(ins[31]) << 20) | (64'(ins[19:12]) << 12) |
                             (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1), 21);
            end
            7'h33, 7'h3b, 7'h0f: ;
            default: e.ill = 1'b1;
        endcase
        e.tgt = pc + e.imm;
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        ent_t e;
        check("a_valid", 64'(a_out_valid), 64'(qa.size() > 0));
        check("a_ready", 64'(a_in_ready), 64'(rdy_a));
        check("b_valid", 64'(b_out_valid), 64'(qa.size() > 0));
        check("b_ready", 64'(b_in_ready), 64'(rdy_a));
        check("c_valid", 64'(c_out_valid), 64'(qc.size() > 0));
        check("c_ready", 64'(c_in_ready), 64'(rdy_c_en && (qc.size() == 0 || out_ready)));
        if (qa.size() > 0) begin
            e = qa[0];
            check("a_imm", 64'(a_out_imm), 64'(e.imm[31:0]));
            check("a_pc",  64'(a_out_pc),  64'(e.pc[31:0]));
            check("a_tgt", 64'(a_out_target), 64'(e.tgt[31:0]));
            check("a_fmt", 64'(a_out_fmt), 64'(e.fmt));
            check("a_ill", 64'(a_out_illegal), 64'(e.ill));
            check("b_imm", b_out_imm, e.imm);
            check("b_pc",  b_out_pc,  e.pc);
            check("b_tgt", b_out_target, e.tgt);
            check("b_fmt", 64'(b_out_fmt), 64'(e.fmt));
            check("b_ill", 64'(b_out_illegal), 64'(e.ill));
        end
        if (qc.size() > 0) begin
            e = qc[0];
            check("c_imm", 64'(c_out_imm), 64'(e.imm[31:0]));
            check("c_pc",  64'(c_out_pc),  64'(e.pc[31:0]));
            check("c_tgt", 64'(c_out_target), 64'(e.tgt[31:0]));
            check("c_fmt", 64'(c_out_fmt), 64'(e.fmt));
        end
    endtask

    // Advance the model on the edge, then compare every DUT one time unit later.
    task automatic tick();
        bit acc_a, drn_a, acc_c, drn_c;
        @(posedge clk);
        acc_a_last = 1'b0;
        if (nRst) begin
            acc_a = in_valid && rdy_a;
            drn_a = (qa.size() > 0) && out_ready;
            acc_c = in_valid && rdy_c_en && (qc.size() == 0 || out_ready);
            drn_c = (qc.size() > 0) && out_ready;
            if (flush) begin
                qa.delete();
                qc.delete();
            end else begin
                if (drn_a) void'(qa.pop_front());
                if (acc_a) qa.push_back(model(in_instr, in_pc));
                if (drn_c) void'(qc.pop_front());
                if (acc_c) qc.push_back(model(in_instr, in_pc));
                acc_a_last = acc_a;
            end
            rdy_a    = (qa.size() < 2);
            rdy_c_en = 1'b1;
        end
        #1;
        cmp_all();
    endtask

    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        in_valid = 1'b1; in_instr = ins; in_pc = pc;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (acc_a_last) begin
                in_valid = 1'b0;
                return;
            end
        end
        n_tests++; n_fail++;
        $display("FAIL send_timeout: instr %h never accepted", ins);
        in_valid = 1'b0;
    endtask

    task automatic reset_model();
        qa.delete(); qc.delete();
        rdy_a = 1'b0; rdy_c_en = 1'b0;
    endtask

    logic [31:0] vec [11];
    logic [31:0] v3  [4];
    int          idx;
    ent_t        me;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec = '{32'hFE112E23, 32'h0080006F, 32'h002081B3, 32'h00001117, 32'h8000001B,
                32'h00000073, 32'h00008067, 32'h0000000F, 32'h80000063, 32'h800000EF,
                32'h0000005B};
        v3  = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
        n_tests = 0; n_fail = 0;
        nRst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_pc = 64'd0;
        reset_model();

        // Pin the reference model against hand-decoded encodings.
        me = model(32'hFFF00093, 64'h100);
        check("mdl_i_imm", me.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check("mdl_i_tgt", me.tgt, 64'hFF);
        me = model(32'hFE000EE3, 64'h200);
        check("mdl_b_imm", me.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("mdl_b_tgt", me.tgt, 64'h1FC);
        me = model(32'h0080006F, 64'h0);
        check("mdl_j_imm", me.imm, 64'h8);
        me = model(32'hFE112E23, 64'h0);
        check("mdl_s_imm", me.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        me = model(32'h0000007F, 64'h0);
        check("mdl_ill", 64'(me.ill), 64'd1);

        #1 nRst = 1'b0;
        #1;
        check("rst_a_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_ready", 64'(a_in_ready), 64'd0);
        check("rst_c_ready", 64'(c_in_ready), 64'd0);
        check("rst_a_imm", 64'(a_out_imm), 64'd0);
        check("rst_b_tgt", b_out_target, 64'd0);
        check("rst_a_fmt", 64'(a_out_fmt), 64'd0);

        #5 nRst = 1'b1;
        #1 check("rdy_before_edge", 64'(a_in_ready), 64'd0);
        tick();
        check("rdy_after_edge", 64'(a_in_ready), 64'd1);

        out_ready = 1'b1;
        send(32'hFFF00093, 64'h100);
        check("lit_i_imm", 64'(a_out_imm), 64'hFFFF_FFFF);
        check("lit_i_fmt", 64'(a_out_fmt), 64'd1);
        check("lit_i_tgt", 64'(a_out_target), 64'hFF);
        check("lit_i_imm64", b_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        send(32'h800002B7, 64'h300);
        check("lit_u_imm64", b_out_imm, 64'hFFFF_FFFF_8000_0000);
        check("lit_u_fmt", 64'(b_out_fmt), 64'd4);
        send(32'hFE000EE3, 64'h200);
        check("lit_b_imm", 64'(a_out_imm), 64'hFFFF_FFFC);
        check("lit_b_fmt", 64'(a_out_fmt), 64'd3);
        check("lit_b_tgt", 64'(a_out_target), 64'h1FC);
        send(32'h0000007F, 64'h204);
        check("lit_ill", 64'(a_out_illegal), 64'd1);
        check("lit_ill_imm", 64'(a_out_imm), 64'd0);

        // Mixed formats under an irregular downstream stall pattern.
        for (int i = 0; i < 11; i++) begin
            out_ready = (i % 3 != 2);
            send(vec[i], 64'h1000 + 64'(4 * i));
        end
        out_ready = 1'b1;
        repeat (3) tick();

        send(32'h02000013, 64'hFFFF_FFF0);
        check("wrap_a_tgt", 64'(a_out_target), 64'h10);
        check("wrap_b_tgt", b_out_target, 64'h1_0000_0010);
        tick();

        // Back-to-back with a stalled consumer: two accepted, third held off.
        out_ready = 1'b0; in_valid = 1'b1; idx = 0;
        for (int k = 0; k < 6; k++) begin
            in_instr = v3[idx]; in_pc = 64'h400 + 64'(4 * idx);
            tick();
            if (acc_a_last && idx < 3) idx++;
        end
        check("skid_accepts", 64'(idx), 64'd2);
        check("skid_full_rdy", 64'(a_in_ready), 64'd0);
        check("skid_head_pc", 64'(a_out_pc), 64'h400);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("skid_promote_pc", 64'(a_out_pc), 64'h404);
        repeat (3) tick();

        // Flush from TWO and from ONE, each with a valid instruction offered.
        out_ready = 1'b0;
        send(32'h00500293, 64'h500);
        send(32'h00600313, 64'h504);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00700393; in_pc = 64'h508;
        tick();
        check("flush_two_valid", 64'(a_out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("flush_two_none", 64'(a_out_valid), 64'd0);
        send(32'h00800413, 64'h50C);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00900493; in_pc = 64'h510;
        tick();
        check("flush_one_valid", 64'(a_out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("flush_one_none", 64'(a_out_valid), 64'd0);

        // Asynchronous reset while holding data.
        send(32'hFFF00093, 64'h600);
        send(32'h800002B7, 64'h604);
        #3 nRst = 1'b0;
        #1;
        reset_model();
        check("arst_a_valid", 64'(a_out_valid), 64'd0);
        check("arst_a_ready", 64'(a_in_ready), 64'd0);
        check("arst_a_imm", 64'(a_out_imm), 64'd0);
        check("arst_a_pc", 64'(a_out_pc), 64'd0);
        check("arst_b_tgt", b_out_target, 64'd0);
        check("arst_b_fmt", 64'(b_out_fmt), 64'd0);
        check("arst_c_valid", 64'(c_out_valid), 64'd0);
        repeat (2) tick();
        #2 nRst = 1'b1;
        #1 check("arst_rdy_low", 64'(a_in_ready), 64'd0);
        tick();
        check("arst_rdy_high", 64'(a_in_ready), 64'd1);
        out_ready = 1'b1;
        send(32'h00A00513, 64'h700);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/t01_imm_gen_pipe.md
T01_IMM_GEN_PIPE -- requirements
Module: t01_imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32; datapath width, legal values 32 and 64.
REQ-002 SHALL have parameter SKID, default 1; 1 = two-entry skid buffer, 0 = single register stage.
REQ-003 SHALL have port clk, input, 1 bit; sole clock, rising edge.
REQ-004 SHALL have port nRst, input, 1 bit; reset, asynchronous, active-low.
REQ-005 SHALL have port flush, input, 1 bit; discards all buffered entries.
REQ-006 SHALL have port in_valid, input, 1 bit; upstream holds a valid instruction.
REQ-007 SHALL have port in_ready, output, 1 bit; block accepts this cycle.
REQ-008 SHALL have port in_instr, input, 32 bits; RV instruction word.
REQ-009 SHALL have port in_pc, input, XLEN bits; address of in_instr.
REQ-010 SHALL have port out_valid, output, 1 bit; output entry valid.
REQ-011 SHALL have port out_ready, input, 1 bit; downstream accepts.
REQ-012 SHALL have port out_imm, output, XLEN bits; sign-extended immediate.
REQ-013 SHALL have port out_fmt, output, 3 bits; format tag NONE/I/S/B/U/J.
REQ-014 SHALL have port out_target, output, XLEN bits; out_pc + out_imm.
REQ-015 SHALL have port out_pc, output, XLEN bits; registered in_pc.
REQ-016 SHALL have port out_illegal, output, 1 bit; opcode not recognised.

Function
REQ-017 Opcodes 03/13/1b/67/73 SHALL decode as I: instr[31:20], sign-extended from bit 31.
REQ-018 Opcode 23 SHALL decode as S: {instr[31:25],instr[11:7]}, sign-extended.
REQ-019 Opcode 63 SHALL decode as B: {instr[31],instr[7],instr[30:25],instr[11:8],0}, sign-extended.
REQ-020 Opcodes 37/17 SHALL decode as U: {instr[31:12],12'b0}, sign-extended to XLEN from bit 31.
REQ-021 Opcode 6f SHALL decode as J: {instr[31],instr[19:12],instr[20],instr[30:21],0}, sign-extended.
REQ-022 Opcodes 33/3b/0f SHALL give fmt NONE, imm 0, illegal 0; all other opcodes fmt NONE, imm 0, illegal 1.
REQ-023 out_target SHALL be out_pc + out_imm modulo 2^XLEN, computed for every format, wrap-around silent.
REQ-024 Transfer in SHALL occur when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-025 Latency SHALL be one cycle: accepted instruction appears on outputs the next cycle.
REQ-026 States SHALL be EMPTY, ONE, TWO (TWO only when SKID=1).
REQ-027 EMPTY: in_ready=1, out_valid=0; accept -> ONE.
REQ-028 ONE: out_valid=1; accept without drain -> TWO (SKID=1); drain without accept -> EMPTY; both -> ONE with new entry.
REQ-029 TWO: in_ready=0; drain -> ONE, skid entry promoted to output.
REQ-030 SKID=0: in_ready = !out_valid | out_ready; never enters TWO.
REQ-031 in_ready SHALL be a registered signal when SKID=1 (no combinational path from out_ready).
REQ-032 Output fields SHALL be held stable while out_valid & !out_ready.
REQ-033 flush SHALL force EMPTY next cycle, overriding simultaneous accept and drain.

Reset
REQ-034 nRst low SHALL immediately force EMPTY, out_valid=0, in_ready=0, out_imm/out_pc/out_target=0, out_fmt=NONE, out_illegal=0.
REQ-035 in_ready SHALL rise on the first clock edge after nRst deasserts; reset mid-transfer discards all entries.

Structure
REQ-036 Format enum (NONE=0,I,S,B,U,J) and opcode constants SHALL live in shared package t01_rv_pkg.
REQ-037 Combinational decode SHALL be sub-module t01_imm_decode (parametrised XLEN), instantiated once at the input.

Verification
REQ-038 XLEN=32, pc=0x100, instr 0xFFF00093 -> next cycle imm 0xFFFFFFFF, fmt I, target 0x000000FF.
REQ-039 XLEN=64, instr 0x800002B7 (lui) -> imm 0xFFFFFFFF80000000, fmt U.
REQ-040 pc=0x200, instr 0xFE000EE3 (beq -4) -> imm 0xFFFFFFFC, fmt B, target 0x1FC; instr 0x0000007F -> illegal 1, imm 0.
REQ-041 SKID=1, out_ready=0, three back-to-back valids -> two accepted, in_ready 0 in TWO; out_ready=1 -> entries drain in order, no loss or duplication.
REQ-042 flush asserted with in_valid=1 in state TWO -> out_valid 0 next cycle, flushed-cycle instruction not accepted.
REQ-043 nRst pulsed low while out_valid=1 -> outputs zero asynchronously, in_ready returns 1 one edge after release.
